// File: rtl/event_flasher_pkg.sv
// -----------------------------------------------------------------------------
// event_flasher_pkg
// Shared constants for the event flasher: FSM state encoding and the width of
// the phase (tick countdown) counter.
// -----------------------------------------------------------------------------
package event_flasher_pkg;

    // Phase counter width; ON_TICKS and OFF_TICKS must fit (1..255).
    localparam int PHASE_BITS = 8;

    // FSM state encoding, kept as plain constants so legacy code can compare
    // against the raw 2-bit state value.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/event_flasher_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running prescaler. It emits a one-cycle tick every 2^TICK_BITS cycles.
// The first tick comes 2^TICK_BITS-1 cycles after reset is released.
//
// Ports:
//   sysclk  in   system clock
//   reset   in   synchronous, active-high
//   tick    out  high for one cycle when the counter is all ones
// -----------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_BITS = 20
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    logic [TICK_BITS-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // its inputs from before the edge. The reset is synchronous, so it is
    // tested inside the clocked block and is not in the sensitivity list.
    always_ff @(posedge sysclk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + 1'b1;  // wraps naturally
    end

    assign tick = &cnt_q;

endmodule

// File: rtl/event_flasher.sv
// -----------------------------------------------------------------------------
// event_flasher
// Turns single-cycle game events into visible and audible signals. Each
// accepted event produces an LED flash of ON_TICKS ticks with a gated square
// wave tone, followed by a gap of OFF_TICKS ticks. Events that arrive during a
// flash are counted and replayed in order. The counter saturates, and any
// event it drops is reported by a one-cycle overflow pulse.
//
// Ports:
//   sysclk    in   system clock
//   reset     in   synchronous, active-high; aborts a flash and clears the queue
//   ev        in   event request, counted once per high cycle
//   out_led   out  high during a flash
//   out_tone  out  buzzer square wave, active only during a flash
//   busy      out  events are queued or the FSM is not idle
//   pending   out  queued events that have not started yet
//   overflow  out  one-cycle pulse in the cycle after an event was dropped
// -----------------------------------------------------------------------------
module event_flasher
    import event_flasher_pkg::*;
#(
    parameter int TICK_BITS   = 20,
    parameter int ON_TICKS    = 3,
    parameter int OFF_TICKS   = 2,
    parameter int QDEPTH_BITS = 3,
    parameter int TONE_BITS   = 15
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   ev,
    output logic                   out_led,
    output logic                   out_tone,
    output logic                   busy,
    output logic [QDEPTH_BITS-1:0] pending,
    output logic                   overflow
);

    localparam logic [PHASE_BITS-1:0]  ON_LOAD  = PHASE_BITS'(ON_TICKS);
    localparam logic [PHASE_BITS-1:0]  OFF_LOAD = PHASE_BITS'(OFF_TICKS);
    localparam logic [QDEPTH_BITS-1:0] PEND_MAX = '1;

    logic                   tick;
    logic                   accept;
    logic [1:0]             state_q,    state_d;
    logic [PHASE_BITS-1:0]  phase_q,    phase_d;
    logic [QDEPTH_BITS-1:0] pending_q,  pending_d;
    logic [TONE_BITS-1:0]   tone_q,     tone_d;
    logic                   overflow_q, overflow_d;

    tick_gen #(
        .TICK_BITS (TICK_BITS)
    ) u_tick_gen (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (tick)
    );

    // Flash sequencer. A start is always aligned to a tick. Pending is read
    // from its register here, so an event that arrives on a tick cycle waits
    // for the next tick.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tone_d  = tone_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick && pending_q != '0) begin
                    state_d = ST_ON;
                    phase_d = ON_LOAD;
                    tone_d  = '0;
                    accept  = 1'b1;
                end
            end
            ST_ON: begin
                tone_d = tone_q + 1'b1;
                if (tick) begin
                    if (phase_q == 8'd1) begin
                        state_d = ST_GAP;
                        phase_d = OFF_LOAD;
                    end else begin
                        phase_d = phase_q - 8'd1;
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    phase_d = phase_q - 8'd1;
                    if (phase_q == 8'd1) begin
                        if (pending_q != '0) begin
                            // Back-to-back replay, with no idle cycle between flashes.
                            state_d = ST_ON;
                            phase_d = ON_LOAD;
                            tone_d  = '0;
                            accept  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pending counter. An accept happens only when pending is nonzero, so the
    // counter cannot wrap below zero. At the maximum, an event is dropped
    // unless an accept frees a slot in the same cycle.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = 1'b0;
        case ({ev, accept})
            2'b10: begin
                if (pending_q != PEND_MAX) pending_d  = pending_q + 1'b1;
                else                       overflow_d = 1'b1;
            end
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;  // idle, or ev and accept cancel out
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            pending_q  <= '0;
            tone_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            pending_q  <= pending_d;
            tone_q     <= tone_d;
            overflow_q <= overflow_d;
        end
    end

    // The outputs are decoded from registers only, so they cannot glitch.
    assign out_led  = (state_q == ST_ON);
    assign out_tone = out_led & tone_q[TONE_BITS-1];
    assign busy     = (pending_q != '0) || (state_q != ST_IDLE);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_event_flasher.sv
// -----------------------------------------------------------------------------
// tb_event_flasher
// Directed bench for event_flasher with small parameters (TICK_BITS=4,
// ON_TICKS=2, OFF_TICKS=1, QDEPTH_BITS=2, TONE_BITS=2). Each scenario schedules
// ev pulses by cycle and pushes the expected output values into a scoreboard
// before the run. Entries are popped and compared on the cycle they name.
// Cycle 0 is the first cycle with reset low.
// -----------------------------------------------------------------------------
module tb_event_flasher;

    localparam int SIG_LED  = 0;
    localparam int SIG_TONE = 1;
    localparam int SIG_BUSY = 2;
    localparam int SIG_PEND = 3;
    localparam int SIG_OVF  = 4;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
    } exp_t;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       ev     = 1'b0;
    logic       out_led;
    logic       out_tone;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    bit   ev_at[0:255];
    string sig_name[5] = '{"led", "tone", "busy", "pending", "overflow"};

    event_flasher #(
        .TICK_BITS   (4),
        .ON_TICKS    (2),
        .OFF_TICKS   (1),
        .QDEPTH_BITS (2),
        .TONE_BITS   (2)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .ev       (ev),
        .out_led  (out_led),
        .out_tone (out_tone),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] observe(input int sig);
        case (sig)
            SIG_LED:  return {7'd0, out_led};
            SIG_TONE: return {7'd0, out_tone};
            SIG_BUSY: return {7'd0, busy};
            SIG_PEND: return {6'd0, pending};
            default:  return {7'd0, overflow};
        endcase
    endfunction

    task automatic push_range(input int sig, input int from, input int to, input int val);
        for (int c = from; c <= to; c++) sb.push_back('{c, sig, 8'(val)});
    endtask

    // The expected tone is the MSB of a 2-bit counter cleared at flash start:
    // two cycles low, then two cycles high, repeating.
    task automatic push_flash(input int from, input int to);
        push_range(SIG_LED, from, to, 1);
        for (int c = from; c <= to; c++) push_range(SIG_TONE, c, c, ((c - from) / 2) % 2);
    endtask

    // Holds reset (with ev high, to show that reset wins) and checks the reset
    // outputs. It returns #1 after the last reset edge, which is inside cycle 0.
    task automatic do_reset(input string name);
        reset = 1'b1;
        ev    = 1'b1;
        @(posedge sysclk);
        @(negedge sysclk);
        check({name, "_rst_led"},  {7'd0, out_led},  8'd0);
        check({name, "_rst_tone"}, {7'd0, out_tone}, 8'd0);
        check({name, "_rst_busy"}, {7'd0, busy},     8'd0);
        check({name, "_rst_pend"}, {6'd0, pending},  8'd0);
        check({name, "_rst_ovf"},  {7'd0, overflow}, 8'd0);
        @(posedge sysclk);
        #1;
        reset = 1'b0;
        ev    = 1'b0;
        foreach (ev_at[i]) ev_at[i] = 1'b0;
    endtask

    // Drives ev from ev_at[] and asserts reset during cycle rst_cyc (-1 for
    // none). Every scoreboard entry for the cycle is compared at the falling edge.
    task automatic run(input string name, input int ncyc, input int rst_cyc);
        for (int c = 0; c < ncyc; c++) begin
            ev    = ev_at[c];
            reset = (c == rst_cyc);
            @(negedge sysclk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == c) begin
                    check($sformatf("%s_%s@%0d", name, sig_name[sb[i].sig], c),
                          observe(sb[i].sig), sb[i].val);
                    sb.delete(i);
                end
            end
            @(posedge sysclk);
            #1;
        end
        ev    = 1'b0;
        reset = 1'b0;
        check({name, "_unchecked_entries"}, 8'(sb.size()), 8'd0);
        sb.delete();
    endtask

    initial begin
        // Single event.
        do_reset("single");
        ev_at[3] = 1'b1;
        push_range(SIG_PEND, 0, 3, 0);  push_range(SIG_PEND, 4, 15, 1);  push_range(SIG_PEND, 16, 70, 0);
        push_range(SIG_LED, 0, 15, 0);  push_flash(16, 47);              push_range(SIG_LED, 48, 70, 0);
        push_range(SIG_TONE, 0, 15, 0); push_range(SIG_TONE, 48, 70, 0);
        push_range(SIG_BUSY, 0, 3, 0);  push_range(SIG_BUSY, 4, 63, 1);  push_range(SIG_BUSY, 64, 70, 0);
        push_range(SIG_OVF, 0, 70, 0);
        run("single", 72, -1);

        // Back-to-back: the second flash follows the gap with no idle cycle.
        do_reset("b2b");
        ev_at[3] = 1'b1; ev_at[20] = 1'b1;
        push_range(SIG_PEND, 4, 15, 1); push_range(SIG_PEND, 16, 20, 0);
        push_range(SIG_PEND, 21, 63, 1); push_range(SIG_PEND, 64, 114, 0);
        push_range(SIG_LED, 0, 15, 0);  push_flash(16, 47); push_range(SIG_LED, 48, 63, 0);
        push_flash(64, 95);             push_range(SIG_LED, 96, 114, 0);
        push_range(SIG_BUSY, 4, 111, 1); push_range(SIG_BUSY, 112, 114, 0);
        run("b2b", 116, -1);

        // Saturation: the fourth event is dropped and exactly three flashes follow.
        do_reset("sat");
        for (int c = 2; c <= 5; c++) ev_at[c] = 1'b1;
        push_range(SIG_PEND, 2, 2, 0);  push_range(SIG_PEND, 3, 3, 1);   push_range(SIG_PEND, 4, 4, 2);
        push_range(SIG_PEND, 5, 15, 3); push_range(SIG_PEND, 16, 63, 2); push_range(SIG_PEND, 64, 111, 1);
        push_range(SIG_PEND, 112, 165, 0);
        push_range(SIG_OVF, 0, 5, 0);   push_range(SIG_OVF, 6, 6, 1);    push_range(SIG_OVF, 7, 165, 0);
        push_flash(16, 47);  push_range(SIG_LED, 48, 63, 0);
        push_flash(64, 95);  push_range(SIG_LED, 96, 111, 0);
        push_flash(112, 143); push_range(SIG_LED, 144, 165, 0);
        push_range(SIG_BUSY, 2, 2, 0); push_range(SIG_BUSY, 3, 159, 1);  push_range(SIG_BUSY, 160, 165, 0);
        run("sat", 168, -1);

        // An event on the accept cycle with the queue full: no change, no overflow.
        do_reset("simul");
        ev_at[2] = 1'b1; ev_at[3] = 1'b1; ev_at[4] = 1'b1; ev_at[15] = 1'b1;
        push_range(SIG_PEND, 5, 20, 3);
        push_range(SIG_OVF, 0, 20, 0);
        push_range(SIG_LED, 15, 15, 0); push_range(SIG_LED, 16, 20, 1);
        run("simul", 24, -1);

        // An event in the same cycle as a tick misses that tick.
        do_reset("sametick");
        ev_at[15] = 1'b1;
        push_range(SIG_PEND, 0, 15, 0); push_range(SIG_PEND, 16, 31, 1); push_range(SIG_PEND, 32, 40, 0);
        push_range(SIG_LED, 0, 31, 0);  push_flash(32, 40);
        push_range(SIG_BUSY, 16, 40, 1);
        run("sametick", 42, -1);

        // Reset mid-flash aborts the flash and discards the queued event.
        do_reset("midrst");
        ev_at[3] = 1'b1; ev_at[20] = 1'b1;
        push_flash(16, 30);
        push_range(SIG_PEND, 21, 30, 1);
        push_range(SIG_LED, 31, 90, 0); push_range(SIG_TONE, 31, 90, 0);
        push_range(SIG_PEND, 31, 90, 0); push_range(SIG_BUSY, 31, 90, 0);
        push_range(SIG_OVF, 31, 90, 0);
        run("midrst", 92, 30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
